// File: rtl/cneuron_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cneuron_pkg
// Description : Shared types for the 2x2 convolution sequencer: sequencer
//               state encoding, pixel width, tap count and the packed
//               4-pixel window vector handed to the neuron.
// Revision    : 1.0 - initial release
// ============================================================================
package cneuron_pkg;

    localparam int PIX_W = 8;
    localparam int TAPS  = 4;

    // tap i occupies bits [PIX_W*i +: PIX_W]
    typedef logic [TAPS-1:0][PIX_W-1:0] pix_vec_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        NEURON = 3'd2,
        OUT    = 3'd3,
        FIN    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cneuron_win_addr.sv
`default_nettype none
// ============================================================================
// Module      : cneuron_win_addr
// Description : Combinational window address generator. For window origin
//               (row, col) and tap k it returns the raster address of
//               pixel (row + k[1], col + k[0]).
// Ports       : i_row  - window origin row
//               i_col  - window origin column
//               i_k    - tap number 0..3 (bit1 = row offset, bit0 = col offset)
//               o_addr - pixel-memory address
// Revision    : 1.0 - initial release
// ============================================================================
module cneuron_win_addr #(
    parameter int IMG_W  = 8,
    parameter int ADDR_W = 16,
    parameter int ROW_W  = 3,
    parameter int COL_W  = 3
) (
    input  logic [ROW_W-1:0]  i_row,
    input  logic [COL_W-1:0]  i_col,
    input  logic [1:0]        i_k,
    output logic [ADDR_W-1:0] o_addr
);

    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_col;

    always_comb begin
        w_row  = ADDR_W'(i_row) + ADDR_W'(i_k[1]);
        w_col  = ADDR_W'(i_col) + ADDR_W'(i_k[0]);
        o_addr = (w_row * ADDR_W'(IMG_W)) + w_col;
    end

endmodule
`default_nettype wire

// File: rtl/cneuron_seq.sv
`default_nettype none
// ============================================================================
// Module      : cneuron_seq
// Description : Sequencer for a 2x2, stride-1 convolution over an 8-bit image
//               in synchronous-read memory. Fetches each window, lets the
//               external neuron register its result, then streams results
//               out in raster order on a valid/ready interface.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               start, kernel_in    - frame request and kernel to latch
//               busy, done          - frame in progress / completion pulse
//               rd_en, rd_addr,
//               rd_data             - pixel memory, 1-cycle read latency
//               nrn_kernel,
//               nrn_pixels,
//               nrn_result          - external neuron interface
//               out_valid, out_ready,
//               out_data, out_idx   - result stream
// Revision    : 1.0 - initial release
// ============================================================================
module cneuron_seq
    import cneuron_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 16,
    parameter int OIDX_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       kernel_in,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [31:0]       nrn_kernel,
    output pix_vec_t          nrn_pixels,
    input  logic [7:0]        nrn_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [OIDX_W-1:0] out_idx
);

    // Window origins only reach IMG-2, so the counters need to hold IMG-2.
    localparam int c_ROW_W = (IMG_H > 2) ? $clog2(IMG_H - 1) : 1;
    localparam int c_COL_W = (IMG_W > 2) ? $clog2(IMG_W - 1) : 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_ROW_W-1:0]   r_row;
    logic [c_COL_W-1:0]   r_col;
    logic [2:0]           r_k;
    logic [OIDX_W-1:0]    r_oidx;
    logic [31:0]          r_kernel;
    pix_vec_t             r_pixels;

    logic                 w_last_col;
    logic                 w_last_row;
    logic [1:0]           w_cap_idx;
    logic [ADDR_W-1:0]    w_addr;

    assign w_last_col = (r_col == c_COL_W'(IMG_W - 2));
    assign w_last_row = (r_row == c_ROW_W'(IMG_H - 2));
    // read data lags the request by one cycle, so tap k lands while r_k = k+1
    assign w_cap_idx  = r_k[1:0] - 2'd1;

    cneuron_win_addr #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W),
        .ROW_W  (c_ROW_W),
        .COL_W  (c_COL_W)
    ) u_win_addr (
        .i_row  (r_row),
        .i_col  (r_col),
        .i_k    (r_k[1:0]),
        .o_addr (w_addr)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        rd_en       = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                rd_en = ~r_k[2];
                if (r_k[2]) begin
                    w_state_nxt = NEURON;
                end
            end
            NEURON: begin
                w_state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = (w_last_col && w_last_row) ? FIN : FETCH;
                end
            end
            FIN: begin
                busy        = 1'b0;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: counters, kernel latch, window capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row    <= '0;
            r_col    <= '0;
            r_k      <= '0;
            r_oidx   <= '0;
            r_kernel <= '0;
            r_pixels <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_kernel <= kernel_in;
                        r_row    <= '0;
                        r_col    <= '0;
                        r_k      <= '0;
                        r_oidx   <= '0;
                    end
                end
                FETCH: begin
                    if (r_k != 3'd0) begin
                        r_pixels[w_cap_idx] <= rd_data;
                    end
                    r_k <= r_k[2] ? 3'd0 : (r_k + 3'd1);
                end
                OUT: begin
                    if (out_ready) begin
                        r_oidx <= r_oidx + OIDX_W'(1);
                        if (!w_last_col) begin
                            r_col <= r_col + c_COL_W'(1);
                        end else if (!w_last_row) begin
                            r_col <= '0;
                            r_row <= r_row + c_ROW_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rd_addr    = rd_en ? w_addr : '0;
    assign nrn_kernel = r_kernel;
    assign nrn_pixels = r_pixels;
    // result is a pass-through of the neuron register; zero when not offered
    assign out_data   = out_valid ? nrn_result : 8'd0;
    assign out_idx    = out_valid ? r_oidx : '0;

endmodule
`default_nettype wire

// File: tb/tb_cneuron_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cneuron_seq
// Description : Self-checking bench for cneuron_seq on a 3x3 image. Models
//               the pixel memory and the external 4-tap neuron, and checks
//               results against a reference convolution of the image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cneuron_seq;
    import cneuron_pkg::*;

    localparam int W  = 3;
    localparam int H  = 3;
    localparam int N  = (W - 1) * (H - 1);
    localparam int AW = 16;
    localparam int OW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   kernel_in;
    logic          busy, done, rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data = 8'd0;
    logic [31:0]   nrn_kernel;
    pix_vec_t      nrn_pixels;
    logic [7:0]    nrn_result = 8'd0;
    logic          out_valid, out_ready;
    logic [7:0]    out_data;
    logic [OW-1:0] out_idx;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [W*H];

    // monitor state (written only by the monitor)
    logic [7:0] got_data [$];
    int         got_idx  [$];
    int         rd_count   = 0;
    int         oob_count  = 0;
    int         done_count = 0;
    int         done_busy  = 0;

    // reference results
    logic [7:0] exp_data [$];
    int         exp_idx  [$];

    // stall samples recorded by run_frame
    logic       st_valid [16];
    logic [7:0] st_data  [16];
    int         st_idx   [16];
    logic       st_rd    [16];
    int         n_stall;

    cneuron_seq #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .OIDX_W(OW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .kernel_in(kernel_in),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .nrn_kernel(nrn_kernel), .nrn_pixels(nrn_pixels),
        .nrn_result(nrn_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx)
    );

    always #5 clk = ~clk;

    // synchronous-read pixel memory
    always @(posedge clk) begin
        if (rd_en) rd_data <= (int'(rd_addr) < W*H) ? mem[rd_addr] : 8'h00;
    end

    // external neuron: registered dot product, modulo 256
    always @(posedge clk) begin
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) s += int'(nrn_kernel[8*i +: 8]) * int'(nrn_pixels[i]);
        nrn_result <= 8'(s);
    end

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_idx.push_back(int'(out_idx));
        end
        if (rd_en) begin
            rd_count++;
            if (int'(rd_addr) >= W*H) oob_count++;
        end
        if (done) begin
            done_count++;
            if (busy) done_busy++;
        end
    end

    // reference convolution straight from the image definition
    task automatic build_ref(input logic [31:0] kv);
        exp_data.delete();
        exp_idx.delete();
        for (int r = 0; r < H - 1; r++) begin
            for (int c = 0; c < W - 1; c++) begin
                int s;
                s = int'(kv[7:0])   * int'(mem[r*W + c])
                  + int'(kv[15:8])  * int'(mem[r*W + c + 1])
                  + int'(kv[23:16]) * int'(mem[(r+1)*W + c])
                  + int'(kv[31:24]) * int'(mem[(r+1)*W + c + 1]);
                exp_data.push_back(8'(s % 256));
                exp_idx.push_back(r * (W - 1) + c);
            end
        end
    endtask

    // Drives one frame; returns in the FIN cycle after the monitor has seen it.
    task automatic run_frame(input bit do_start, input int stall_idx, input int stall_len,
                             input int mid_cycle, input logic [31:0] mid_kernel,
                             output int cycles, output bit timeout);
        int  stall_left;
        bit  stalled;
        stall_left = 0;
        stalled    = 0;
        n_stall    = 0;
        out_ready  = 1'b1;
        if (do_start) begin
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        cycles  = 0;
        timeout = 0;
        while (!done) begin
            if (cycles >= 400) begin
                timeout = 1;
                break;
            end
            if (!stalled && stall_idx >= 0 && out_valid && int'(out_idx) == stall_idx) begin
                stalled    = 1;
                stall_left = stall_len;
            end
            if (stall_left > 0) begin
                out_ready         = 1'b0;
                st_valid[n_stall] = out_valid;
                st_data[n_stall]  = out_data;
                st_idx[n_stall]   = int'(out_idx);
                st_rd[n_stall]    = rd_en;
                n_stall++;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            start = (cycles == mid_cycle);
            if (cycles == mid_cycle) kernel_in = mid_kernel;
            @(posedge clk); #1;
            cycles++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        #5;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; kernel_in = 32'hA5A5_A5A5;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({busy, done, rd_en, out_valid} !== 4'b0000) begin errors++;
            $display("FAIL reset_ctrl: got %b required 0000", {busy, done, rd_en, out_valid}); end
        checks++; if (rd_addr !== '0) begin errors++;
            $display("FAIL reset_rd_addr: got %0h required 0", rd_addr); end
        checks++; if (nrn_pixels !== '0) begin errors++;
            $display("FAIL reset_pixels: got %0h required 0", nrn_pixels); end
        checks++; if (nrn_kernel !== '0) begin errors++;
            $display("FAIL reset_kernel: got %0h required 0", nrn_kernel); end
        checks++; if (out_data !== 8'd0 || out_idx !== '0) begin errors++;
            $display("FAIL reset_out: got data %0h idx %0d required 0/0", out_data, out_idx); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL idle_no_start: busy %b required 0", busy); end
    endtask

    task automatic test_patterns();
        logic [31:0] kv [4];
        int cyc, b_out, b_rd, b_done, b_db;
        bit to;
        kv[0] = 32'h0101_0101; kv[1] = 32'h0000_0002; kv[2] = 32'h0101_0101;
        kv[3] = $urandom;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < W*H; i++)
                mem[i] = (t == 2) ? 8'hFF : ((t == 3) ? 8'($urandom) : 8'(i + 1));
            kernel_in = kv[t];
            build_ref(kv[t]);
            b_out = got_data.size(); b_rd = rd_count; b_done = done_count; b_db = done_busy;
            run_frame(1, -1, 0, -1, 32'h0, cyc, to);
            checks++; if (to) begin errors++; $display("FAIL pat%0d_timeout: no done in 400 cycles", t); end
            checks++; if (got_data.size() - b_out !== N) begin errors++;
                $display("FAIL pat%0d_count: got %0d required %0d", t, got_data.size() - b_out, N); end
            for (int i = 0; i < N && b_out + i < got_data.size(); i++) begin
                checks++; if (got_data[b_out+i] !== exp_data[i] || got_idx[b_out+i] !== exp_idx[i]) begin errors++;
                    $display("FAIL pat%0d_out%0d: got %0h@%0d required %0h@%0d", t, i,
                             got_data[b_out+i], got_idx[b_out+i], exp_data[i], exp_idx[i]); end
            end
            checks++; if (cyc !== 7*N) begin errors++;
                $display("FAIL pat%0d_latency: got %0d required %0d", t, cyc, 7*N); end
            checks++; if (done_count - b_done !== 1 || done_busy !== b_db) begin errors++;
                $display("FAIL pat%0d_done: got %0d pulses (%0d with busy) required 1 (0)", t,
                         done_count - b_done, done_busy - b_db); end
            checks++; if (rd_count - b_rd !== 4*N || oob_count !== 0) begin errors++;
                $display("FAIL pat%0d_reads: got %0d (%0d oob) required %0d (0)", t,
                         rd_count - b_rd, oob_count, 4*N); end
        end
    endtask

    task automatic test_backpressure();
        int cyc, b_out, b_rd;
        bit to;
        logic [31:0] k;
        for (int i = 0; i < W*H; i++) mem[i] = 8'($urandom);
        k = $urandom;
        kernel_in = k;
        build_ref(k);
        b_out = got_data.size(); b_rd = rd_count;
        run_frame(1, 1, 10, -1, 32'h0, cyc, to);
        checks++; if (to || n_stall !== 10) begin errors++;
            $display("FAIL bp_stall: timeout %0d stall cycles %0d required 0/10", to, n_stall); end
        for (int i = 0; i < n_stall; i++) begin
            checks++; if (st_valid[i] !== 1'b1 || st_data[i] !== exp_data[1] || st_idx[i] !== 1 || st_rd[i] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v%b %0h@%0d rd%b required v1 %0h@1 rd0", i,
                         st_valid[i], st_data[i], st_idx[i], st_rd[i], exp_data[1]); end
        end
        checks++; if (got_data.size() - b_out !== N) begin errors++;
            $display("FAIL bp_count: got %0d required %0d", got_data.size() - b_out, N); end
        for (int i = 0; i < N && b_out + i < got_data.size(); i++) begin
            checks++; if (got_data[b_out+i] !== exp_data[i] || got_idx[b_out+i] !== exp_idx[i]) begin errors++;
                $display("FAIL bp_out%0d: got %0h@%0d required %0h@%0d", i,
                         got_data[b_out+i], got_idx[b_out+i], exp_data[i], exp_idx[i]); end
        end
        checks++; if (cyc !== 7*N + 10) begin errors++;
            $display("FAIL bp_latency: got %0d required %0d", cyc, 7*N + 10); end
        checks++; if (rd_count - b_rd !== 4*N) begin errors++;
            $display("FAIL bp_reads: got %0d required %0d", rd_count - b_rd, 4*N); end
    endtask

    task automatic test_mid_start();
        int cyc, b_out, b_done;
        bit to;
        logic [31:0] k;
        for (int i = 0; i < W*H; i++) mem[i] = 8'($urandom);
        k = $urandom;
        kernel_in = k;
        build_ref(k);
        b_out = got_data.size(); b_done = done_count;
        run_frame(1, -1, 0, 5, ~k, cyc, to);
        checks++; if (to || cyc !== 7*N) begin errors++;
            $display("FAIL mid_latency: got %0d (timeout %0d) required %0d", cyc, to, 7*N); end
        checks++; if (got_data.size() - b_out !== N || done_count - b_done !== 1) begin errors++;
            $display("FAIL mid_count: got %0d outputs %0d done required %0d/1",
                     got_data.size() - b_out, done_count - b_done, N); end
        for (int i = 0; i < N && b_out + i < got_data.size(); i++) begin
            checks++; if (got_data[b_out+i] !== exp_data[i] || got_idx[b_out+i] !== exp_idx[i]) begin errors++;
                $display("FAIL mid_out%0d: got %0h@%0d required %0h@%0d", i,
                         got_data[b_out+i], got_idx[b_out+i], exp_data[i], exp_idx[i]); end
        end
        checks++; if (nrn_kernel !== k) begin errors++;
            $display("FAIL mid_kernel: got %0h required %0h", nrn_kernel, k); end
    endtask

    task automatic test_fin_start();
        int cyc, b_out;
        bit to;
        logic [31:0] k;
        for (int i = 0; i < W*H; i++) mem[i] = 8'($urandom);
        k = $urandom;
        kernel_in = k;
        build_ref(k);
        run_frame(1, -1, 0, -1, 32'h0, cyc, to);
        start = 1'b1;                   // seen in FIN: must be ignored
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
            $display("FAIL fin_start_ignored: busy %b done %b required 0/0", busy, done); end
        b_out = got_data.size();
        @(posedge clk); #1;             // start held into first IDLE cycle
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++;
            $display("FAIL idle_start_taken: busy %b required 1", busy); end
        run_frame(0, -1, 0, -1, 32'h0, cyc, to);
        checks++; if (to || cyc !== 7*N || got_data.size() - b_out !== N) begin errors++;
            $display("FAIL fin_frame: cycles %0d outputs %0d required %0d/%0d",
                     cyc, got_data.size() - b_out, 7*N, N); end
        for (int i = 0; i < N && b_out + i < got_data.size(); i++) begin
            checks++; if (got_data[b_out+i] !== exp_data[i] || got_idx[b_out+i] !== exp_idx[i]) begin errors++;
                $display("FAIL fin_out%0d: got %0h@%0d required %0h@%0d", i,
                         got_data[b_out+i], got_idx[b_out+i], exp_data[i], exp_idx[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int cyc, n, b_out, b_done;
        bit to;
        logic [31:0] k;
        for (int i = 0; i < W*H; i++) mem[i] = 8'($urandom);
        k = $urandom;
        kernel_in = k;
        build_ref(k);
        out_ready = 1'b1;
        b_done = done_count;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (!(out_valid && out_idx == 2) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (n >= 200) begin errors++; $display("FAIL rst_wait: output 2 never offered"); end
        rst = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin errors++;
            $display("FAIL rst_abort: busy %b valid %b done %b required 0/0/0", busy, out_valid, done); end
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (done_count !== b_done || busy !== 1'b0) begin errors++;
            $display("FAIL rst_no_done: %0d pulses busy %b required 0/0", done_count - b_done, busy); end
        b_out = got_data.size();
        run_frame(1, -1, 0, -1, 32'h0, cyc, to);
        checks++; if (to || cyc !== 7*N || got_data.size() - b_out !== N) begin errors++;
            $display("FAIL rst_refram: cycles %0d outputs %0d required %0d/%0d",
                     cyc, got_data.size() - b_out, 7*N, N); end
        for (int i = 0; i < N && b_out + i < got_data.size(); i++) begin
            checks++; if (got_data[b_out+i] !== exp_data[i] || got_idx[b_out+i] !== exp_idx[i]) begin errors++;
                $display("FAIL rst_out%0d: got %0h@%0d required %0h@%0d", i,
                         got_data[b_out+i], got_idx[b_out+i], exp_data[i], exp_idx[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_backpressure();
        test_mid_start();
        test_fin_start();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cneuron_seq.md
Name: cneuron_seq

Overview:
- Sequencer that runs a 2x2, stride-1 convolution over an 8-bit grayscale image held in a synchronous-read pixel memory.
- It drives one external 4-tap convolution neuron, which has a 32-bit packed kernel input, a 4x8-bit pixel input and one registered 8-bit result.
- For each output position it fetches the four window pixels and presents them to the neuron. It then returns the result on a valid/ready output stream in raster order.
- It sits between the image buffer and the feature-map writer in the ML convolution layer.

Parameters:
- IMG_W, 8, image width in pixels, range 2..256.
- IMG_H, 8, image height in pixels, range 2..256.
- ADDR_W, 16, pixel-memory address width. Must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- OIDX_W, 16, output-index width. Must satisfy 2^OIDX_W >= (IMG_W-1)*(IMG_H-1).

Ports:
- clk, input, 1, the single clock; all logic is on its rising edge.
- rst, input, 1, reset; synchronous, active-high.
- start, input, 1, one-cycle request to begin a frame.
- kernel_in, input, 32, kernel weights, 4x8-bit packed; weight i is bits [8i+7:8i].
- busy, output, 1, high while a frame is in progress.
- done, output, 1, one-cycle pulse when a frame is complete.
- rd_en, output, 1, pixel-memory read enable.
- rd_addr, output, ADDR_W, pixel address, computed as row*IMG_W+col.
- rd_data, input, 8, pixel data, valid exactly 1 cycle after rd_en.
- nrn_kernel, output, 32, kernel driven to the neuron.
- nrn_pixels, output, 4x8, window pixels driven to the neuron.
- nrn_result, input, 8, neuron registered result.
- out_valid, output, 1, result available on out_data.
- out_ready, input, 1, downstream accepts the result.
- out_data, output, 8, convolution result.
- out_idx, output, OIDX_W, output index, computed as r*(IMG_W-1)+c.

Behaviour:
- Reset values (applied at the first clk edge with rst=1):
  - state=IDLE.
  - busy, done, rd_en, out_valid = 0.
  - rd_addr, nrn_pixels, nrn_kernel, out_data, out_idx = 0.
  - row/column counters = 0.
- rst=1 mid-frame aborts the frame immediately with no done pulse.
- FSM states: IDLE, FETCH, NEURON, OUT, FIN.
- IDLE:
  - start=1 latches kernel_in into nrn_kernel, clears r and c to 0, and moves to FETCH.
  - start seen in any other state is ignored.
  - busy=1 in every state except IDLE.
- FETCH: sub-counter k runs 0..4.
  - For k<4: rd_en=1; rd_addr = (r+k[1])*IMG_W + (c+k[0]).
  - Window order: pixel0=(r,c), pixel1=(r,c+1), pixel2=(r+1,c), pixel3=(r+1,c+1).
  - For k>=1: rd_data is captured into nrn_pixels[k-1].
  - At k=4, rd_en=0 and the state moves to NEURON.
  - FETCH lasts 5 cycles.
- NEURON: 1 cycle. nrn_pixels and nrn_kernel are held stable so the neuron registers its result at the end of this cycle. Then go to OUT.
- OUT:
  - out_valid=1; out_data=nrn_result (combinational pass-through); out_idx=r*(IMG_W-1)+c.
  - nrn_pixels is held, so out_data stays stable while out_ready=0 (backpressure of any length).
  - On out_valid && out_ready:
    - If c < IMG_W-2: c++, go to FETCH.
    - Else if r < IMG_H-2: c=0, r++, go to FETCH.
    - Else go to FIN.
- FIN: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
  - A start arriving in the FIN cycle is ignored.
  - A start on the first IDLE cycle after FIN is accepted.
- Throughput: 7 cycles per output with out_ready held at 1. A frame takes 7*(IMG_W-1)*(IMG_H-1) cycles from the start edge to the done pulse, plus 1 cycle for FIN.
- Arithmetic: the neuron result is modulo 256. The sequencer passes it through unchanged and does no saturation.
- nrn_kernel is stable for the whole frame. kernel_in changes mid-frame have no effect.
- There are no reads outside the image. The maximum address is (IMG_H-1)*IMG_W + IMG_W-1.

Decomposition:
- Package cneuron_pkg holds:
  - the state enum (IDLE, FETCH, NEURON, OUT, FIN);
  - PIX_W=8 and TAPS=4;
  - a typedef pix_vec_t, a 4x8 packed vector.
- Natural sub-module: cneuron_win_addr, a combinational window address generator taking (r, c, k) and producing rd_addr.
- The neuron stays external; the bench instantiates it.

Test Plan:
- IMG_W=IMG_H=3, pixels 1..9 in raster order, kernel 0x01010101, out_ready=1 -> outputs 12,16,24,28 with idx 0..3, one done pulse, 28 cycles from start to done.
- Same image, kernel 0x00000002 (weight0=2) -> outputs 2,4,8,10.
- Pixels all 0xFF, kernel 0x01010101 -> every output is 0xFC (modulo-256 wrap).
- Hold out_ready=0 for 10 cycles on output 1 -> out_valid, out_data and out_idx are stable throughout, no extra reads occur, the frame completes correctly, and done is delayed by 10 cycles.
- Pulse start at cycle 5 mid-frame, and change kernel_in at the same time -> ignored; results are unchanged.
- Assert rst during the OUT state of output 2 -> next cycle busy=0, out_valid=0, no done pulse. A following start produces the full frame again from idx 0.
